// File: rtl/xif_offload_ctrl_if.sv
// Coprocessor-side eXtension interface bundle: issue, register, commit and result channels.
// The master modport is the CPU side and the slave modport is the coprocessor side.
interface xif_offload_ctrl_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2
);
  logic                       issue_valid;
  logic                       issue_ready;
  logic [33+X_ID_WIDTH:0]     issue_req;
  logic [2+X_NUM_RS:0]        issue_resp;
  logic                       register_valid;
  logic                       register_ready;
  logic [X_ID_WIDTH-1:0]      register_id;
  logic [32*X_NUM_RS-1:0]     register_rs;
  logic                       commit_valid;
  logic [X_ID_WIDTH:0]        commit;
  logic                       result_valid;
  logic                       result_ready;
  logic [X_ID_WIDTH+46:0]     result;

  modport master (
    output issue_valid, issue_req, register_valid, register_id, register_rs,
           commit_valid, commit, result_ready,
    input  issue_ready, issue_resp, register_ready, result_valid, result
  );
  modport slave (
    input  issue_valid, issue_req, register_valid, register_id, register_rs,
           commit_valid, commit, result_ready,
    output issue_ready, issue_resp, register_ready, result_valid, result
  );
endinterface

// File: rtl/xif_offload_ctrl.sv
// CPU-side eXtension interface offload controller: issue/register sequencing, commit queue, result writeback.
// Defining XIF_STATS_EN adds the saturating stat_accepted / stat_rejected / stat_killed outputs.
module xif_offload_ctrl #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       off_valid,
  output logic                       off_ready,
  input  logic [31:0]                off_instr,
  input  logic [32*X_NUM_RS-1:0]     off_rs,
  output logic                       off_done,
  output logic                       off_accept,
  input  logic                       cmt_valid,
  input  logic                       cmt_kill,
  xif_offload_ctrl_if.master         xif,
  output logic                       wb_valid,
  output logic [4:0]                 wb_rd,
  output logic [31:0]                wb_data,
  output logic [$clog2(DEPTH+1)-1:0] inflight
`ifdef XIF_STATS_EN
  ,
  output logic [31:0]                stat_accepted,
  output logic [31:0]                stat_rejected,
  output logic [31:0]                stat_killed
`endif
);
  localparam int IW  = X_ID_WIDTH;
  localparam int CW  = $clog2(DEPTH+1);
  localparam int RSW = 32*X_NUM_RS;

  typedef enum logic [1:0] {IDLE, ISSUE, REG} state_e;
  state_e state, state_nx;

  logic [31:0]              instr_q;
  logic [RSW-1:0]           rs_q;
  logic [IW-1:0]            id_q, id_cnt;

  logic [DEPTH-1:0]         t_vld, t_wb, t_cmt, t_kill, t_pend, t_pwr;
  logic [DEPTH-1:0][IW-1:0] t_id;
  logic [DEPTH-1:0][4:0]    t_rd;
  logic [DEPTH-1:0][31:0]   t_data;

  // Commit queue, oldest uncommitted ID at index 0.
  logic [DEPTH-1:0][IW-1:0] cq;
  logic [CW-1:0]            cq_cnt, cq_wr;

  logic                     hs_issue, resp_acc, resp_wb, alloc, pop, id_busy;
  logic                     fresh_wb, drain_wb;
  logic [IW-1:0]            pop_id, r_id;
  logic [31:0]              r_data, dr_data;
  logic [4:0]               r_rd, dr_rd;
  logic                     r_we;
  logic [DEPTH-1:0]         alloc_oh, cmt_now, cmt_eff, kill_eff, hit, hold, free, drain_oh;
  logic                     unused_bits;

  assign resp_acc    = xif.issue_resp[X_NUM_RS+2];
  assign resp_wb     = xif.issue_resp[X_NUM_RS+1];
  assign r_id        = xif.result[IW+46:47];
  assign r_data      = xif.result[46:15];
  assign r_rd        = xif.result[14:10];
  assign r_we        = xif.result[9];
  assign unused_bits = ^{xif.result[8:0], xif.issue_resp[X_NUM_RS:0]};

  assign hs_issue = (state == ISSUE) && xif.issue_ready;
  assign alloc    = hs_issue && resp_acc;
  assign pop      = cmt_valid && (cq_cnt != '0);
  assign pop_id   = cq[0];
  assign cq_wr    = cq_cnt - CW'(pop);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (off_valid && off_ready) state_nx = ISSUE;
      ISSUE:   if (xif.issue_ready)        state_nx = resp_acc ? REG : IDLE;
      REG:     if (xif.register_ready)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    xif.issue_valid    = (state == ISSUE);
    xif.register_valid = (state == REG);
    off_done           = hs_issue;
    off_accept         = hs_issue && resp_acc;
  end

  // Payloads are gated so the buses read zero whenever no transaction is pending.
  assign xif.issue_req    = xif.issue_valid ? {instr_q, 2'b11, id_q} : '0;
  assign xif.register_id  = xif.register_valid ? id_q : '0;
  assign xif.register_rs  = xif.register_valid ? rs_q : '0;
  assign xif.result_ready = 1'b1;
  assign off_ready        = (state == IDLE) && (inflight < CW'(DEPTH)) && !id_busy;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      instr_q <= '0;
      rs_q    <= '0;
      id_q    <= '0;
      id_cnt  <= '0;
    end else begin
      if (state == IDLE && off_valid && off_ready) begin
        instr_q <= off_instr;
        rs_q    <= off_rs;
        id_q    <= id_cnt;
      end
      if (hs_issue) id_cnt <= id_cnt + 1'b1;
    end
  end

  // A commit in the same cycle as a result for that ID is folded in before the result is judged.
  always_comb begin
    alloc_oh = '0; drain_oh = '0; cmt_now = '0; cmt_eff = '0; kill_eff = '0; hit = '0;
    id_busy = 1'b0; fresh_wb = 1'b0; drain_wb = 1'b0; inflight = '0;
    dr_rd = '0; dr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_now[i]  = pop && t_vld[i] && (t_id[i] == pop_id);
      cmt_eff[i]  = t_cmt[i] | cmt_now[i];
      kill_eff[i] = t_kill[i] | (cmt_now[i] & cmt_kill);
      hit[i]      = xif.result_valid && t_vld[i] && !t_pend[i] && (t_id[i] == r_id);
      if (hit[i] && cmt_eff[i] && !kill_eff[i] && t_wb[i] && r_we) fresh_wb = 1'b1;
      if (t_vld[i] && (t_id[i] == id_cnt)) id_busy = 1'b1;
      inflight = inflight + CW'(t_vld[i]);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!t_vld[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = alloc;
      end
      // A held-off result drains only when the writeback port is not claimed by a fresh result.
      if (!fresh_wb && t_vld[i] && t_cmt[i] && t_pend[i]) begin
        drain_oh    = '0;
        drain_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (drain_oh[i]) begin
        drain_wb = t_pwr[i] & ~t_kill[i];
        dr_rd    = t_rd[i];
        dr_data  = t_data[i];
      end
    end
    free = (hit & cmt_eff) | drain_oh;
    hold = hit & ~cmt_eff;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      t_vld <= '0; t_wb <= '0; t_cmt <= '0; t_kill <= '0; t_pend <= '0; t_pwr <= '0;
      t_id  <= '0; t_rd <= '0; t_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          t_vld[i]  <= 1'b1;
          t_id[i]   <= id_q;
          t_wb[i]   <= resp_wb;
          t_cmt[i]  <= 1'b0;
          t_kill[i] <= 1'b0;
          t_pend[i] <= 1'b0;
        end else begin
          if (free[i]) t_vld[i] <= 1'b0;
          if (cmt_now[i]) begin
            t_cmt[i]  <= 1'b1;
            t_kill[i] <= cmt_kill;
          end
          if (hold[i]) begin
            t_pend[i] <= 1'b1;
            t_pwr[i]  <= t_wb[i] & r_we;
            t_rd[i]   <= r_rd;
            t_data[i] <= r_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cq     <= '0;
      cq_cnt <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH-1; i++) cq[i] <= cq[i+1];
      if (alloc)
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cq_wr) cq[i] <= id_q;
      cq_cnt <= cq_cnt + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      xif.commit_valid <= 1'b0;
      xif.commit       <= '0;
      wb_valid         <= 1'b0;
      wb_rd            <= '0;
      wb_data          <= '0;
    end else begin
      xif.commit_valid <= pop;
      if (pop) xif.commit <= {pop_id, cmt_kill};
      wb_valid <= fresh_wb | drain_wb;
      if (fresh_wb) begin
        wb_rd   <= r_rd;
        wb_data <= r_data;
      end else if (drain_wb) begin
        wb_rd   <= dr_rd;
        wb_data <= dr_data;
      end
    end
  end

`ifdef XIF_STATS_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stat_accepted <= '0;
      stat_rejected <= '0;
      stat_killed   <= '0;
    end else begin
      if (hs_issue && resp_acc && stat_accepted != '1)  stat_accepted <= stat_accepted + 32'd1;
      if (hs_issue && !resp_acc && stat_rejected != '1) stat_rejected <= stat_rejected + 32'd1;
      if (pop && cmt_kill && stat_killed != '1)         stat_killed   <= stat_killed + 32'd1;
    end
  end
`endif

endmodule
